// File: rtl/mac_pkg.sv
// Width defaults and the shared shift/saturate helper for the mac_array datapath.
package mac_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int LANES_DEF  = 4;
    localparam int ACC_W_DEF  = 2 * DATA_W_DEF + 8;
    localparam int OUT_W_DEF  = 16;
    localparam int SHIFT_DEF  = 8;

    // Working width of sat_shift; accumulators up to 63 bits fit with sign headroom.
    localparam int SAT_W = 64;

    typedef struct packed {
        logic signed [SAT_W-1:0] value;
        logic                    sat;
    } sat_res_t;

    // Floor shift then clamp to a signed out_w range; value comes back sign-extended.
    function automatic sat_res_t sat_shift(input logic signed [SAT_W-1:0] acc,
                                           input int unsigned             shift,
                                           input int unsigned             out_w);
        logic signed [SAT_W-1:0] s;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_res_t                res;
        s         = acc >>> shift;
        hi        = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo        = -(64'sd1 <<< (out_w - 1));
        res.value = s;
        res.sat   = 1'b0;
        if (s > hi) begin
            res.value = hi;
            res.sat   = 1'b1;
        end else if (s < lo) begin
            res.value = lo;
            res.sat   = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mac_array_if.sv
// Operand stream in, completed group results out; the engine is always ready.
interface mac_array_if
    import mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int OUT_W  = OUT_W_DEF
);
    logic                      in_valid;
    logic                      in_first;
    logic                      in_last;
    logic [LANES*DATA_W-1:0]   in_a;
    logic [LANES*DATA_W-1:0]   in_b;
    logic                      out_valid;
    logic [LANES*OUT_W-1:0]    out_data;
    logic [LANES-1:0]          out_sat;

    modport master (
        output in_valid, in_first, in_last, in_a, in_b,
        input  out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_first, in_last, in_a, in_b,
        output out_valid, out_data, out_sat
    );
endinterface

// File: rtl/mac_lane.sv
// One MAC lane: operand capture, product, accumulator and saturated output register.
module mac_lane
    import mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int SHIFT  = SHIFT_DEF
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    input  logic                     v0_i,
    input  logic                     v1_i,
    input  logic                     first1_i,
    input  logic                     emit_i,
    output logic [OUT_W-1:0]         data_o,
    output logic                     sat_o
);

    logic signed [DATA_W-1:0]   a_q, a_d;
    logic signed [DATA_W-1:0]   b_q, b_d;
    logic signed [2*DATA_W-1:0] prod_q, prod_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [ACC_W-1:0]    prod_ext;
    logic [OUT_W-1:0]           data_q, data_d;
    logic                       sat_q, sat_d;
    sat_res_t                   sat_res;

    assign prod_ext = {{(ACC_W - 2*DATA_W){prod_q[2*DATA_W-1]}}, prod_q};

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        prod_d = prod_q;
        acc_d  = acc_q;
        data_d = data_q;
        sat_d  = sat_q;
        if (in_valid_i) begin
            a_d = a_i;
            b_d = b_i;
        end
        if (v0_i) begin
            prod_d = a_q * b_q;
        end
        // Accumulator wraps modulo 2^ACC_W; a first beat replaces rather than adds.
        if (v1_i) begin
            acc_d = first1_i ? prod_ext : acc_q + prod_ext;
        end
        sat_res = sat_shift({{(SAT_W - ACC_W){acc_q[ACC_W-1]}}, acc_q}, SHIFT, OUT_W);
        if (emit_i) begin
            data_d = OUT_W'(sat_res.value);
            sat_d  = sat_res.sat;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            acc_q  <= '0;
            data_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            prod_q <= prod_d;
            acc_q  <= acc_d;
            data_q <= data_d;
            sat_q  <= sat_d;
        end
    end

    assign data_o = data_q;
    assign sat_o  = sat_q;

endmodule

// File: rtl/mac_array.sv
// LANES-wide signed MAC engine: shared control pipeline plus one mac_lane per lane.
module mac_array
    import mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int SHIFT  = SHIFT_DEF
) (
    input  logic          clock,
    input  logic          reset_n,
    mac_array_if.slave    bus
);

    // Stage 0 registers the beat, 1 holds the product, 2 the accumulator, 3 the output.
    logic v0_q, f0_q, l0_q;
    logic v1_q, f1_q, l1_q;
    logic v2_q;
    logic out_valid_q;

    logic [OUT_W-1:0]       lane_data [LANES];
    logic                   lane_sat  [LANES];
    logic [LANES*OUT_W-1:0] out_data_w;
    logic [LANES-1:0]       out_sat_w;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            v0_q        <= 1'b0;
            f0_q        <= 1'b0;
            l0_q        <= 1'b0;
            v1_q        <= 1'b0;
            f1_q        <= 1'b0;
            l1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            v0_q        <= bus.in_valid;
            f0_q        <= bus.in_valid & bus.in_first;
            l0_q        <= bus.in_valid & bus.in_last;
            v1_q        <= v0_q;
            f1_q        <= f0_q;
            l1_q        <= l0_q;
            v2_q        <= v1_q & l1_q;
            out_valid_q <= v2_q;
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            mac_lane #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W),
                .OUT_W  (OUT_W),
                .SHIFT  (SHIFT)
            ) u_lane (
                .clock      (clock),
                .reset_n    (reset_n),
                .in_valid_i (bus.in_valid),
                .a_i        (bus.in_a[gi*DATA_W +: DATA_W]),
                .b_i        (bus.in_b[gi*DATA_W +: DATA_W]),
                .v0_i       (v0_q),
                .v1_i       (v1_q),
                .first1_i   (f1_q),
                .emit_i     (v2_q),
                .data_o     (lane_data[gi]),
                .sat_o      (lane_sat[gi])
            );
        end
    endgenerate

    always_comb begin
        out_data_w = '0;
        out_sat_w  = '0;
        for (int i = 0; i < LANES; i++) begin
            out_data_w[i*OUT_W +: OUT_W] = lane_data[i];
            out_sat_w[i]                 = lane_sat[i];
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_w;
    assign bus.out_sat   = out_sat_w;

endmodule

// File: tb/tb_mac_array.sv
// Directed bench for mac_array at default widths; expected values are hand-computed.
module tb_mac_array;

    logic clock;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    mac_array_if #(.DATA_W(16), .LANES(4), .OUT_W(16)) bus ();

    mac_array #(
        .DATA_W (16),
        .LANES  (4),
        .ACC_W  (40),
        .OUT_W  (16),
        .SHIFT  (8)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic beat(input logic f, input logic l, input logic [63:0] a, input logic [63:0] b);
        bus.in_valid = 1'b1;
        bus.in_first = f;
        bus.in_last  = l;
        bus.in_a     = a;
        bus.in_b     = b;
        tick();
    endtask

    // Idle cycles with junk on first/last to show they are ignored without valid.
    task automatic bubble(input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b0;
            bus.in_first = 1'($urandom_range(0, 1));
            bus.in_last  = 1'($urandom_range(0, 1));
            bus.in_a     = {$urandom, $urandom};
            bus.in_b     = {$urandom, $urandom};
            tick();
        end
    endtask

    // Called right after the last beat: pulse must appear on exactly the third edge after it.
    task automatic expect_result(input string tag, input logic [63:0] data, input logic [3:0] sat);
        bubble(2);
        chk({tag, "_early"}, 64'(bus.out_valid), 64'd0);
        bubble(1);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_data"},  bus.out_data, data);
        chk({tag, "_sat"},   64'(bus.out_sat), 64'(sat));
        bubble(1);
        chk({tag, "_pulse"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_hold"},  bus.out_data, data);
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        tick();
        tick();
        tick();
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data",  bus.out_data, 64'd0);
        chk("rst_sat",   64'(bus.out_sat), 64'd0);
        reset_n = 1'b1;
        tick();

        // No first after reset: accumulates onto the cleared acc. 0x100*0x500>>8 = 0x500.
        beat(1'b0, 1'b1, {4{16'h0100}}, {4{16'h0500}});
        expect_result("nofirst", {4{16'h0500}}, 4'h0);

        // Single-beat group: 0x100*0x200 = 0x20000, >>8 = 0x200.
        beat(1'b1, 1'b1, {4{16'h0100}}, {4{16'h0200}});
        expect_result("single", {4{16'h0200}}, 4'h0);

        // -3*5 four times = -60, floor(-60/256) = -1.
        beat(1'b1, 1'b0, {4{16'hFFFD}}, {4{16'h0005}});
        beat(1'b0, 1'b0, {4{16'hFFFD}}, {4{16'h0005}});
        beat(1'b0, 1'b0, {4{16'hFFFD}}, {4{16'h0005}});
        beat(1'b0, 1'b1, {4{16'hFFFD}}, {4{16'h0005}});
        expect_result("neg_floor", {4{16'hFFFF}}, 4'h0);

        // Positive saturation.
        beat(1'b1, 1'b0, {4{16'h7FFF}}, {4{16'h7FFF}});
        beat(1'b0, 1'b0, {4{16'h7FFF}}, {4{16'h7FFF}});
        beat(1'b0, 1'b0, {4{16'h7FFF}}, {4{16'h7FFF}});
        beat(1'b0, 1'b1, {4{16'h7FFF}}, {4{16'h7FFF}});
        expect_result("sat_pos", {4{16'h7FFF}}, 4'hF);

        // Negative saturation: 2 * (-32768*32767) >> 8 = -8388352.
        beat(1'b1, 1'b0, {4{16'h8000}}, {4{16'h7FFF}});
        beat(1'b0, 1'b1, {4{16'h8000}}, {4{16'h7FFF}});
        expect_result("sat_neg", {4{16'h8000}}, 4'hF);

        // Distinct lanes with bubbles. Sums: lane0 172400->0x02A1, lane1 899999936->sat,
        // lane2 -1072719056->sat, lane3 -400->0xFFFE.
        beat(1'b1, 1'b0, {16'h0064, 16'hFF38, 16'h0007, 16'h03E8},
                         {16'h0003, 16'h0032, 16'hFFF7, 16'h012C});
        bubble(1);
        beat(1'b0, 1'b0, {16'h0000, 16'hFC18, 16'h7530, 16'hFE0C},
                         {16'h0000, 16'hFC18, 16'h7530, 16'h0100});
        bubble(3);
        beat(1'b0, 1'b1, {16'hFFF9, 16'h8000, 16'hFFFF, 16'h0014},
                         {16'h0064, 16'h7FFF, 16'h0001, 16'h0014});
        expect_result("lanes", {16'hFFFE, 16'h8000, 16'h7FFF, 16'h02A1}, 4'b0110);

        // Back-to-back: A = 2 * 0x30000 >> 8 = 0x600, B = 0x100*1 >> 8 = 1.
        beat(1'b1, 1'b0, {4{16'h0100}}, {4{16'h0300}});
        beat(1'b0, 1'b1, {4{16'h0100}}, {4{16'h0300}});
        beat(1'b1, 1'b1, {4{16'h0100}}, {4{16'h0001}});
        bubble(1);
        chk("b2b_early", 64'(bus.out_valid), 64'd0);
        bubble(1);
        chk("b2b_a_valid", 64'(bus.out_valid), 64'd1);
        chk("b2b_a_data",  bus.out_data, {4{16'h0600}});
        bubble(1);
        chk("b2b_b_valid", 64'(bus.out_valid), 64'd1);
        chk("b2b_b_data",  bus.out_data, {4{16'h0001}});
        bubble(1);
        chk("b2b_end", 64'(bus.out_valid), 64'd0);

        // Reset in the middle of a group: last beat arrives with reset, nothing emerges.
        beat(1'b1, 1'b0, {4{16'h0100}}, {4{16'h0100}});
        beat(1'b0, 1'b0, {4{16'h0100}}, {4{16'h0100}});
        beat(1'b0, 1'b0, {4{16'h0100}}, {4{16'h0100}});
        reset_n = 1'b0;
        beat(1'b0, 1'b1, {4{16'h0100}}, {4{16'h0100}});
        reset_n = 1'b1;
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_data",  bus.out_data, 64'd0);
        chk("mid_rst_sat",   64'(bus.out_sat), 64'd0);
        for (int i = 0; i < 5; i++) begin
            bubble(1);
            chk("mid_rst_quiet", 64'(bus.out_valid), 64'd0);
        end

        // Clean group after reset: 0x80*0x500 = 0x28000, >>8 = 0x280.
        beat(1'b1, 1'b1, {4{16'h0080}}, {4{16'h0500}});
        expect_result("post_rst", {4{16'h0280}}, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
